// File: rtl/ace_snoop_responder.sv
// ----------------------------------------------------------------------------
// ace_snoop_responder
//
// Purpose:
//   Cache-side endpoint of the ACE snoop channels for one core. It accepts one
//   snoop at a time on AC and issues a single lookup/state-change request to the
//   data cache. It then returns the snoop response on CR and, when the response
//   carries DataTransfer, the full line on CD as Beats wrapping beats that start
//   at the beat addressed by the snoop.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   ac_valid_i/ready_o   snoop address handshake; ac_addr_i, ac_snoop_i payload
//   cr_valid_o/ready_i   snoop response handshake; cr_resp_o =
//                        {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   cd_valid_o/ready_i   snoop data handshake; cd_data_o beat, cd_last_o
//   lk_req_o/gnt_i       cache lookup request; lk_addr_o line address, lk_op_o
//                        0 KEEP / 1 SHARE / 2 INVALIDATE
//   lk_rvalid_i          one-cycle lookup result with lk_hit_i, lk_dirty_i,
//                        lk_shared_i, lk_data_i (state/data before the op)
// ----------------------------------------------------------------------------
module ace_snoop_responder #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lk_req_o,
    input  logic                 lk_gnt_i,
    output logic [AddrWidth-1:0] lk_addr_o,
    output logic [1:0]           lk_op_o,
    input  logic                 lk_rvalid_i,
    input  logic                 lk_hit_i,
    input  logic                 lk_dirty_i,
    input  logic                 lk_shared_i,
    input  logic [LineWidth-1:0] lk_data_i
);

    localparam int Beats    = LineWidth / DataWidth;
    localparam int BeatW    = $clog2(Beats);
    localparam int LineOffW = $clog2(LineWidth / 8);
    localparam int DataOffW = $clog2(DataWidth / 8);

    localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineWidth / 8 - 1);
    localparam logic [BeatW-1:0]     LastCnt  = BeatW'(Beats - 1);

    localparam logic [1:0] OP_KEEP  = 2'd0;
    localparam logic [1:0] OP_SHARE = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;

    localparam logic [4:0] RESP_ERROR = 5'b00010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_DATA   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Snoop code decode helpers
    // ------------------------------------------------------------------------
    function automatic logic snoop_supported(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1001, 4'b1000, 4'b1101: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] snoop_op(input logic [3:0] code);
        case (code)
            4'b0000:                            return OP_KEEP;
            4'b0001, 4'b0010, 4'b0011, 4'b1000: return OP_SHARE;
            4'b0111, 4'b1001, 4'b1101:          return OP_INVAL;
            default:                            return OP_KEEP;
        endcase
    endfunction

    // Response bits {WU,IS,PD,Error,DT}; a miss answers all-zero.
    function automatic logic [4:0] snoop_resp(input logic [3:0] code,
                                              input logic       hit,
                                              input logic       dirty,
                                              input logic       shared);
        logic wu;
        wu = ~shared;
        if (!hit) begin
            return 5'b00000;
        end else begin
            case (code)
                4'b0000:                   return {wu, 1'b1, 1'b0,  1'b0, 1'b1};
                4'b0001, 4'b0010, 4'b0011: return {wu, 1'b1, dirty, 1'b0, 1'b1};
                4'b0111:                   return {wu, 1'b0, dirty, 1'b0, 1'b1};
                4'b1001:                   return {wu, 1'b0, dirty, 1'b0, dirty};
                4'b1000:                   return {wu, 1'b1, dirty, 1'b0, dirty};
                4'b1101:                   return {wu, 1'b0, 1'b0,  1'b0, 1'b0};
                default:                   return RESP_ERROR;
            endcase
        end
    endfunction

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_next_state;

    logic [3:0]             r_snoop;
    logic [BeatW-1:0]       r_start;
    logic [BeatW-1:0]       r_beat;
    logic [BeatW-1:0]       r_cnt;
    logic [LineWidth-1:0]   r_line;

    logic                   r_ac_ready;
    logic                   r_cr_valid;
    logic [4:0]             r_cr_resp;
    logic                   r_cd_valid;
    logic [DataWidth-1:0]   r_cd_data;
    logic                   r_cd_last;
    logic                   r_lk_req;
    logic [AddrWidth-1:0]   r_lk_addr;
    logic [1:0]             r_lk_op;

    logic                   w_ac_hs;
    logic [BeatW-1:0]       w_sel;
    logic [BeatW-1:0]       w_nxt_beat;
    logic [BeatW-1:0]       w_nxt_cnt;
    logic [4:0]             w_nxt_cr_resp;
    logic [DataWidth-1:0]   w_nxt_cd_data;
    logic                   w_nxt_cd_last;
    logic [AddrWidth-1:0]   w_nxt_lk_addr;
    logic [1:0]             w_nxt_lk_op;

    // ac_ready_o is only ever high in IDLE, so this is the AC handshake.
    assign w_ac_hs = ac_valid_i & r_ac_ready;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ac_hs) begin
                    if (snoop_supported(ac_snoop_i)) begin
                        w_next_state = S_LOOKUP;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (lk_gnt_i) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_WAIT: begin
                if (lk_rvalid_i) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP: begin
                if (cr_ready_i) begin
                    if (r_cr_resp[0]) begin
                        w_next_state = S_DATA;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_RESP;
                end
            end
            S_DATA: begin
                if (cd_ready_i && r_cd_last) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the beat counters.
    always_comb begin
        w_sel         = r_beat;
        w_nxt_beat    = r_beat;
        w_nxt_cnt     = r_cnt;
        w_nxt_cr_resp = r_cr_resp;
        w_nxt_cd_data = r_cd_data;
        w_nxt_cd_last = r_cd_last;
        w_nxt_lk_addr = r_lk_addr;
        w_nxt_lk_op   = r_lk_op;

        if (w_ac_hs) begin
            w_nxt_lk_addr = ac_addr_i & ~LineMask;
            w_nxt_lk_op   = snoop_op(ac_snoop_i);
            if (snoop_supported(ac_snoop_i)) begin
                w_nxt_cr_resp = r_cr_resp;
            end else begin
                w_nxt_cr_resp = RESP_ERROR;
            end
        end else if (r_state == S_WAIT && lk_rvalid_i) begin
            w_nxt_cr_resp = snoop_resp(r_snoop, lk_hit_i, lk_dirty_i, lk_shared_i);
        end else begin
            w_nxt_cr_resp = r_cr_resp;
        end

        // First beat is the critical one addressed by the snoop; the line then
        // wraps through the remaining beats.
        if (r_state == S_RESP && cr_ready_i && r_cr_resp[0]) begin
            w_sel         = r_start;
            w_nxt_beat    = r_start;
            w_nxt_cnt     = {BeatW{1'b0}};
            w_nxt_cd_data = r_line[int'(w_sel) * DataWidth +: DataWidth];
            w_nxt_cd_last = 1'b0;
        end else if (r_state == S_DATA && cd_ready_i) begin
            if (r_cd_last) begin
                w_nxt_cd_last = 1'b0;
            end else begin
                w_sel         = r_beat + BeatW'(1'b1);
                w_nxt_beat    = w_sel;
                w_nxt_cnt     = r_cnt + BeatW'(1'b1);
                w_nxt_cd_data = r_line[int'(w_sel) * DataWidth +: DataWidth];
                w_nxt_cd_last = (w_nxt_cnt == LastCnt);
            end
        end else begin
            w_nxt_cd_last = r_cd_last;
        end
    end

    // Output registers: handshake flags follow the next state so every
    // output is a flop and all of them clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ac_ready <= 1'b0;
            r_cr_valid <= 1'b0;
            r_cr_resp  <= 5'b00000;
            r_cd_valid <= 1'b0;
            r_cd_data  <= {DataWidth{1'b0}};
            r_cd_last  <= 1'b0;
            r_lk_req   <= 1'b0;
            r_lk_addr  <= {AddrWidth{1'b0}};
            r_lk_op    <= 2'd0;
            r_beat     <= {BeatW{1'b0}};
            r_cnt      <= {BeatW{1'b0}};
        end else begin
            r_ac_ready <= (w_next_state == S_IDLE);
            r_cr_valid <= (w_next_state == S_RESP);
            r_cr_resp  <= w_nxt_cr_resp;
            r_cd_valid <= (w_next_state == S_DATA);
            r_cd_data  <= w_nxt_cd_data;
            r_cd_last  <= w_nxt_cd_last;
            r_lk_req   <= (w_next_state == S_LOOKUP);
            r_lk_addr  <= w_nxt_lk_addr;
            r_lk_op    <= w_nxt_lk_op;
            r_beat     <= w_nxt_beat;
            r_cnt      <= w_nxt_cnt;
        end
    end

    // Snoop context and line capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snoop <= 4'b0000;
            r_start <= {BeatW{1'b0}};
            r_line  <= {LineWidth{1'b0}};
        end else begin
            if (w_ac_hs) begin
                r_snoop <= ac_snoop_i;
                r_start <= ac_addr_i[LineOffW-1:DataOffW];
            end else begin
                r_snoop <= r_snoop;
                r_start <= r_start;
            end
            if (r_state == S_WAIT && lk_rvalid_i) begin
                r_line <= lk_data_i;
            end else begin
                r_line <= r_line;
            end
        end
    end

    assign ac_ready_o = r_ac_ready;
    assign cr_valid_o = r_cr_valid;
    assign cr_resp_o  = r_cr_resp;
    assign cd_valid_o = r_cd_valid;
    assign cd_data_o  = r_cd_data;
    assign cd_last_o  = r_cd_last;
    assign lk_req_o   = r_lk_req;
    assign lk_addr_o  = r_lk_addr;
    assign lk_op_o    = r_lk_op;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// ----------------------------------------------------------------------------
// tb_ace_snoop_responder
//
// Scoreboard bench: each issued snoop pushes its expected lookup, CR response
// and CD beats into queues computed from the snoop rules; independent monitor
// and cache-responder processes pop and compare whenever the DUT presents a
// handshake. Inputs change 1 time unit after posedge, outputs are sampled on
// negedge.
// ----------------------------------------------------------------------------
module tb_ace_snoop_responder;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LW    = 128;
    localparam int BEATS = LW / DW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ac_valid_i = 1'b0;
    logic          ac_ready_o;
    logic [AW-1:0] ac_addr_i = '0;
    logic [3:0]    ac_snoop_i = 4'h0;
    logic          cr_valid_o;
    logic          cr_ready_i = 1'b0;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o;
    logic          cd_ready_i = 1'b0;
    logic [DW-1:0] cd_data_o;
    logic          cd_last_o;
    logic          lk_req_o;
    logic          lk_gnt_i = 1'b0;
    logic [AW-1:0] lk_addr_o;
    logic [1:0]    lk_op_o;
    logic          lk_rvalid_i = 1'b0;
    logic          lk_hit_i = 1'b0;
    logic          lk_dirty_i = 1'b0;
    logic          lk_shared_i = 1'b0;
    logic [LW-1:0] lk_data_i = '0;

    ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
        .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
        .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
        .lk_req_o(lk_req_o), .lk_gnt_i(lk_gnt_i),
        .lk_addr_o(lk_addr_o), .lk_op_o(lk_op_o),
        .lk_rvalid_i(lk_rvalid_i), .lk_hit_i(lk_hit_i), .lk_dirty_i(lk_dirty_i),
        .lk_shared_i(lk_shared_i), .lk_data_i(lk_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          hit;
        logic          dirty;
        logic          shared;
        logic [LW-1:0] data;
    } line_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [4:0]    exp_cr[$];
    logic [DW:0]   exp_cd[$];      // {last, data}
    logic [AW+1:0] exp_lk[$];      // {op, line address}
    line_t         cache_q[$];

    int gnt_pct = 100;
    int cr_pct  = 100;
    int cd_pct  = 100;
    int rv_max  = 1;

    int ac_hs_cyc    = 0;
    int cr_rise_cyc  = 0;
    int cd_rise_cyc  = 0;
    int lk_req_count = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected lookup, CR and CD from the snoop rules, then
    // drive AC until it is accepted.
    task automatic send(input logic [3:0] code, input logic [AW-1:0] addr,
                        input logic hit, input logic dirty, input logic shared,
                        input logic [LW-1:0] data);
        logic       sup, dt, is_sh, pd, hs;
        logic [1:0] op;
        logic [4:0] resp;
        line_t      ln;
        int         start, b, n;
        sup = 1'b1; dt = 1'b0; is_sh = 1'b0; pd = 1'b0; op = 2'd0;
        case (code)
            4'h0:             begin op = 2'd0; dt = 1'b1;  is_sh = 1'b1; pd = 1'b0;  end
            4'h1, 4'h2, 4'h3: begin op = 2'd1; dt = 1'b1;  is_sh = 1'b1; pd = dirty; end
            4'h7:             begin op = 2'd2; dt = 1'b1;  is_sh = 1'b0; pd = dirty; end
            4'h9:             begin op = 2'd2; dt = dirty; is_sh = 1'b0; pd = dirty; end
            4'h8:             begin op = 2'd1; dt = dirty; is_sh = 1'b1; pd = dirty; end
            4'hD:             begin op = 2'd2; dt = 1'b0;  is_sh = 1'b0; pd = 1'b0;  end
            default:          sup = 1'b0;
        endcase
        if (!sup)      resp = 5'b00010;
        else if (!hit) resp = 5'b00000;
        else           resp = {!shared, is_sh, pd, 1'b0, dt};
        exp_cr.push_back(resp);
        if (sup) begin
            exp_lk.push_back({op, addr - (addr % 64'd16)});
            ln.hit = hit; ln.dirty = dirty; ln.shared = shared; ln.data = data;
            cache_q.push_back(ln);
        end
        if (resp[0]) begin
            start = int'((addr % 64'd16) / 64'd8);
            for (int i = 0; i < BEATS; i++) begin
                b = (start + i) % BEATS;
                exp_cd.push_back({(i == BEATS - 1) ? 1'b1 : 1'b0, data[b*DW +: DW]});
            end
        end
        @(posedge clk_i); #1;
        ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = code;
        hs = 1'b0; n = 0;
        while (!hs && n < 300) begin
            @(negedge clk_i);
            if (ac_ready_o) begin hs = 1'b1; ac_hs_cyc = cyc; end
            n++;
        end
        if (!hs) check("ac_accept_timeout", 1'b0, 1'b1);
        @(posedge clk_i); #1;
        ac_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 600 && !(exp_cr.size() == 0 && exp_cd.size() == 0 && ac_ready_o === 1'b1)) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 600) check("idle_timeout", 1'b0, 1'b1);
    endtask

    // Ready drivers.
    initial forever begin
        @(posedge clk_i); #1;
        cr_ready_i = ($urandom_range(0, 99) < cr_pct);
        cd_ready_i = ($urandom_range(0, 99) < cd_pct);
    end

    // Cache model: grants requests, checks lookup payload, returns the line.
    initial begin
        int    rv_cnt;
        line_t cur;
        logic [AW+1:0] e;
        rv_cnt = 0;
        cur.hit = 1'b0; cur.dirty = 1'b0; cur.shared = 1'b0; cur.data = '0;
        forever begin
            @(posedge clk_i); #1;
            lk_rvalid_i = 1'b0;
            lk_data_i   = {$urandom, $urandom, $urandom, $urandom};
            if (rst_i) begin
                rv_cnt   = 0;
                lk_gnt_i = 1'b0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        lk_rvalid_i = 1'b1;
                        lk_hit_i    = cur.hit;
                        lk_dirty_i  = cur.dirty;
                        lk_shared_i = cur.shared;
                        lk_data_i   = cur.data;
                    end
                end
                lk_gnt_i = 1'b0;
                if (lk_req_o && ($urandom_range(0, 99) < gnt_pct)) begin
                    lk_gnt_i = 1'b1;
                    rv_cnt   = $urandom_range(1, rv_max);
                    if (exp_lk.size() == 0) begin
                        check("lk_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = exp_lk.pop_front();
                        check("lk_addr", lk_addr_o, e[AW-1:0]);
                        check("lk_op", lk_op_o, e[AW+1:AW]);
                    end
                    if (cache_q.size() > 0) cur = cache_q.pop_front();
                end
            end
        end
    end

    // Monitor: scoreboard pops, stall stability, exclusivity.
    initial begin
        logic          p_cr_v, p_cd_v, p_cr_st, p_cd_st, p_cd_last;
        logic [4:0]    p_cr_resp;
        logic [DW-1:0] p_cd_data;
        logic [4:0]    ecr;
        logic [DW:0]   ecd;
        p_cr_v = 1'b0; p_cd_v = 1'b0; p_cr_st = 1'b0; p_cd_st = 1'b0;
        p_cd_last = 1'b0; p_cr_resp = '0; p_cd_data = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                p_cr_v = 1'b0; p_cd_v = 1'b0; p_cr_st = 1'b0; p_cd_st = 1'b0;
            end else begin
                if (cr_valid_o && !p_cr_v) cr_rise_cyc = cyc;
                if (cd_valid_o && !p_cd_v) cd_rise_cyc = cyc;
                if (p_cr_st) begin
                    check("cr_hold_valid", cr_valid_o, 1'b1);
                    check("cr_hold_resp", cr_resp_o, p_cr_resp);
                end
                if (p_cd_st) begin
                    check("cd_hold_valid", cd_valid_o, 1'b1);
                    check("cd_hold_data", cd_data_o, p_cd_data);
                    check("cd_hold_last", cd_last_o, p_cd_last);
                end
                if (lk_req_o || cr_valid_o || cd_valid_o) check("ac_ready_busy", ac_ready_o, 1'b0);
                if (cr_valid_o) check("cr_cd_overlap", cd_valid_o, 1'b0);
                if (cr_valid_o && cr_ready_i) begin
                    if (exp_cr.size() == 0) begin
                        check("cr_unexpected", 1'b1, 1'b0);
                    end else begin
                        ecr = exp_cr.pop_front();
                        check("cr_resp", cr_resp_o, ecr);
                    end
                end
                if (cd_valid_o && cd_ready_i) begin
                    if (exp_cd.size() == 0) begin
                        check("cd_unexpected", 1'b1, 1'b0);
                    end else begin
                        ecd = exp_cd.pop_front();
                        check("cd_data", cd_data_o, ecd[DW-1:0]);
                        check("cd_last", cd_last_o, ecd[DW]);
                    end
                end
                if (lk_req_o) lk_req_count++;
                p_cr_v = cr_valid_o; p_cd_v = cd_valid_o;
                p_cr_st = cr_valid_o && !cr_ready_i;
                p_cd_st = cd_valid_o && !cd_ready_i;
                p_cr_resp = cr_resp_o; p_cd_data = cd_data_o; p_cd_last = cd_last_o;
            end
        end
    end

    // Watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]    sup_codes [8];
        logic [3:0]    code;
        logic [LW-1:0] d;
        int            n, lkc;
        sup_codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9, 4'h8, 4'hD};

        // Reset values.
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ac_ready", ac_ready_o, 1'b0);
        check("rst_cr_valid", cr_valid_o, 1'b0);
        check("rst_cd_valid", cd_valid_o, 1'b0);
        check("rst_cd_last", cd_last_o, 1'b0);
        check("rst_lk_req", lk_req_o, 1'b0);
        check("rst_outputs", {cr_resp_o, cd_data_o, lk_addr_o, lk_op_o}, '0);
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        check("post_rst_ac_ready", ac_ready_o, 1'b1);

        // Minimum-latency ReadShared, hit dirty unshared.
        d = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        send(4'h1, 64'h8000_0040, 1'b1, 1'b1, 1'b0, d);
        wait_idle();
        check("lat_cr", cr_rise_cyc - ac_hs_cyc, 3);
        check("lat_cd", cd_rise_cyc - ac_hs_cyc, 4);

        // ReadOnce with start beat 1, hit clean shared: wrap order.
        send(4'h0, 64'h8000_0048, 1'b1, 1'b0, 1'b1, d);
        wait_idle();

        // CleanInvalid hit clean, then miss.
        send(4'h9, 64'h8000_0080, 1'b1, 1'b0, 1'b0, d);
        wait_idle();
        send(4'h9, 64'h8000_00C0, 1'b0, 1'b0, 1'b0, d);
        wait_idle();

        // Unsupported code: no lookup, error response one cycle after AC.
        lkc = lk_req_count;
        send(4'h5, 64'h8000_0100, 1'b1, 1'b1, 1'b0, d);
        wait_idle();
        check("unsup_lat_cr", cr_rise_cyc - ac_hs_cyc, 1);
        check("unsup_no_lookup", lk_req_count - lkc, 0);
        check("unsup_ac_ready", ac_ready_o, 1'b1);

        // Backpressure on grant, CR and CD.
        gnt_pct = 0; cr_pct = 0; cd_pct = 50; rv_max = 3;
        send(4'h7, 64'h8000_0148, 1'b1, 1'b1, 1'b0, {64'hAAAA_0000_BBBB_0001, 64'hCCCC_0002_DDDD_0003});
        repeat (5) @(posedge clk_i);
        gnt_pct = 100;
        n = 0;
        while (!cr_valid_o && n < 50) begin @(negedge clk_i); n++; end
        check("bp_cr_seen", cr_valid_o, 1'b1);
        repeat (3) @(posedge clk_i);
        cr_pct = 100;
        wait_idle();
        cd_pct = 100; rv_max = 1;

        // Reset during DATA after beat 0.
        send(4'h1, 64'h8000_0200, 1'b1, 1'b0, 1'b0, {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444});
        n = 0;
        while (!(cd_valid_o && cd_ready_i) && n < 50) begin @(negedge clk_i); n++; end
        check("rst_data_beat0_seen", cd_valid_o, 1'b1);
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        check("mid_rst_valids", {cr_valid_o, cd_valid_o, cd_last_o, lk_req_o, ac_ready_o}, 5'b00000);
        check("mid_rst_cd_left", exp_cd.size(), 1);
        exp_cd.delete(); exp_cr.delete(); exp_lk.delete(); cache_q.delete();
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        check("rel_ac_ready_0", ac_ready_o, 1'b0);
        @(negedge clk_i);
        check("rel_ac_ready_1", ac_ready_o, 1'b1);
        send(4'h2, 64'h8000_0248, 1'b1, 1'b1, 1'b1, {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666});
        wait_idle();

        // Randomized traffic under random backpressure.
        for (int t = 0; t < 80; t++) begin
            gnt_pct = $urandom_range(30, 100);
            cr_pct  = $urandom_range(30, 100);
            cd_pct  = $urandom_range(30, 100);
            rv_max  = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(0, 15));
            else                           code = sup_codes[$urandom_range(0, 7)];
            send(code, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        gnt_pct = 100; cr_pct = 100; cd_pct = 100;
        wait_idle();
        check("end_cr_queue", exp_cr.size(), 0);
        check("end_cd_queue", exp_cd.size(), 0);
        check("end_lk_queue", exp_lk.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
